// File: rtl/shape_pkg.sv
// shape_pkg: FSM states, default geometry and cell indexing shared by the shape pixel engine
package shape_pkg;
  typedef enum logic [1:0] {IDLE, ROTATE, PENDING} state_t;
  localparam int DEF_CELL_SIZE = 16;
  localparam int DEF_EDGE_W = 1;
  localparam int DEF_COORD_W = 10;
  function automatic int cell_idx(input int r, input int c, input int grid);
    return r * grid + c;
  endfunction
endpackage

// File: rtl/shape_cell_hit.sv
// shape_cell_hit: classifies one pixel against one cell as interior, edge or miss
module shape_cell_hit
  import shape_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int CELL_SIZE = DEF_CELL_SIZE,
  parameter int EDGE_W = DEF_EDGE_W
) (
  input  logic [COORD_W-1:0]        pix_x,
  input  logic [COORD_W-1:0]        pix_y,
  input  logic signed [COORD_W+1:0] ox,
  input  logic signed [COORD_W+1:0] oy,
  output logic                      is_inner,
  output logic                      is_edge
);
  localparam int W = COORD_W + 3;
  logic signed [W-1:0] dx, dy;
  logic hx, hy, ix, iy;
  // offsets from the cell origin; negative means left of / above the cell
  always_comb begin
    dx = $signed({3'b000, pix_x}) - W'(ox);
    dy = $signed({3'b000, pix_y}) - W'(oy);
    hx = !dx[W-1] && dx <= W'(CELL_SIZE - 1);
    hy = !dy[W-1] && dy <= W'(CELL_SIZE - 1);
    ix = dx >= W'(EDGE_W) && dx <= W'(CELL_SIZE - 1 - EDGE_W);
    iy = dy >= W'(EDGE_W) && dy <= W'(CELL_SIZE - 1 - EDGE_W);
    is_inner = ix & iy;
    is_edge = hx & hy & ~is_inner;
  end
endmodule

// File: rtl/shape_pixel_engine.sv
// shape_pixel_engine: per-pixel shape classifier with shadow shape committed at frame start
// SHAPE_ROTATE_EN enables clockwise rotation of the shadow mask via rot_req
module shape_pixel_engine
  import shape_pkg::*;
#(
  parameter int GRID = 3,
  parameter int CELL_SIZE = DEF_CELL_SIZE,
  parameter int EDGE_W = DEF_EDGE_W,
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   shape_valid,
  output logic                   shape_ready,
  input  logic [GRID*GRID-1:0]   shape_mask,
  input  logic [COORD_W-1:0]     shape_ref_x,
  input  logic [COORD_W-1:0]     shape_ref_y,
  input  logic                   rot_req,
  output logic                   busy,
  output logic                   pending,
  input  logic                   pix_valid,
  input  logic [COORD_W-1:0]     pix_x,
  input  logic [COORD_W-1:0]     pix_y,
  output logic                   out_valid,
  output logic                   out_inner,
  output logic                   out_edge
);
  localparam int N = GRID * GRID;
  localparam int H = (GRID - 1) / 2;
  localparam int CW = COORD_W + 2;
  localparam int KW = $clog2(N);
  state_t state, state_n;
  logic [N-1:0] act_mask, sh_mask, in_v, ed_v, s1_in, s1_ed;
  logic [COORD_W-1:0] act_rx, act_ry, sh_rx, sh_ry;
  logic signed [CW-1:0] ox [GRID];
  logic signed [CW-1:0] oy [GRID];
  logic load, commit, rot_go, rot_last, v1;
  assign shape_ready = state == IDLE;
  assign pending = state == PENDING;
  assign load = shape_valid & shape_ready;
  assign commit = pending & frame_start;
`ifdef SHAPE_ROTATE_EN
  logic [KW-1:0] k, src;
  assign rot_go = rot_req;
  assign rot_last = k == KW'(N - 1);
  assign busy = state == ROTATE;
  // shadow[r][c] takes active[GRID-1-c][r]
  assign src = KW'((GRID - 1 - k % GRID) * GRID + k / GRID);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) k <= '0;
    else k <= (state == ROTATE) ? k + 1'b1 : '0;
`else
  logic unused_rot;
  assign unused_rot = rot_req;
  assign rot_go = 1'b0;
  assign rot_last = 1'b0;
  assign busy = 1'b0;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = load ? PENDING : rot_go ? ROTATE : IDLE;
      ROTATE:  state_n = rot_last ? PENDING : ROTATE;
      PENDING: state_n = frame_start ? IDLE : PENDING;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      act_mask <= '0;
      sh_mask <= '0;
      act_rx <= '0;
      act_ry <= '0;
      sh_rx <= '0;
      sh_ry <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        sh_mask <= shape_mask;
        sh_rx <= shape_ref_x;
        sh_ry <= shape_ref_y;
      end
      if (commit) begin
        act_mask <= sh_mask;
        act_rx <= sh_rx;
        act_ry <= sh_ry;
      end
`ifdef SHAPE_ROTATE_EN
      if (state == ROTATE) sh_mask[k] <= act_mask[src];
`endif
    end
  end
  for (genvar c = 0; c < GRID; c++) begin : g_org
    assign ox[c] = $signed({2'b00, act_rx}) + CW'((c - H) * CELL_SIZE);
    assign oy[c] = $signed({2'b00, act_ry}) + CW'((c - H) * CELL_SIZE);
  end
  for (genvar r = 0; r < GRID; r++) begin : g_row
    for (genvar c = 0; c < GRID; c++) begin : g_cell
      localparam int I = cell_idx(r, c, GRID);
      shape_cell_hit #(
        .COORD_W(COORD_W),
        .CELL_SIZE(CELL_SIZE),
        .EDGE_W(EDGE_W)
      ) u_hit (
        .pix_x(pix_x),
        .pix_y(pix_y),
        .ox(ox[c]),
        .oy(oy[r]),
        .is_inner(in_v[I]),
        .is_edge(ed_v[I])
      );
    end
  end
  // mask is applied in stage 1 so a commit lines up with the ref used for the same pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1_in <= '0;
      s1_ed <= '0;
      out_valid <= 1'b0;
      out_inner <= 1'b0;
      out_edge <= 1'b0;
    end else begin
      v1 <= pix_valid;
      s1_in <= pix_valid ? in_v & act_mask : '0;
      s1_ed <= pix_valid ? ed_v & act_mask : '0;
      out_valid <= v1;
      out_inner <= |s1_in;
      out_edge <= |s1_ed & ~|s1_in;
    end
  end
endmodule

// File: tb/tb_shape_pixel_engine.sv
// tb_shape_pixel_engine: directed self-checking bench for shape_pixel_engine
module tb_shape_pixel_engine;
  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, shape_valid = 1'b0, rot_req = 1'b0, pix_valid = 1'b0;
  logic [8:0] shape_mask = '0;
  logic [9:0] shape_ref_x = '0, shape_ref_y = '0, pix_x = '0, pix_y = '0;
  logic shape_ready, busy, pending, out_valid, out_inner, out_edge;
  int checks = 0, passes = 0;

  shape_pixel_engine dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .shape_valid(shape_valid), .shape_ready(shape_ready), .shape_mask(shape_mask),
    .shape_ref_x(shape_ref_x), .shape_ref_y(shape_ref_y), .rot_req(rot_req),
    .busy(busy), .pending(pending), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .out_valid(out_valid), .out_inner(out_inner), .out_edge(out_edge)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [8:0] m, input logic [9:0] x, input logic [9:0] y);
    shape_valid = 1'b1; shape_mask = m; shape_ref_x = x; shape_ref_y = y;
    tick;
    shape_valid = 1'b0;
  endtask

  task automatic commit;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
  endtask

  task automatic send_pix(input logic [9:0] x, input logic [9:0] y, output logic [2:0] o);
    pix_valid = 1'b1; pix_x = x; pix_y = y;
    tick;
    pix_valid = 1'b0;
    tick;
    o = {out_valid, out_inner, out_edge};
  endtask

  task automatic test_reset;
    tick; rst_n = 1'b1; tick;
    checks++; if ({shape_ready, busy, pending} !== 3'b100) $display("FAIL reset_status got %b exp 100", {shape_ready, busy, pending}); else passes++;
    checks++; if ({out_valid, out_inner, out_edge} !== 3'b000) $display("FAIL reset_out got %b exp 000", {out_valid, out_inner, out_edge}); else passes++;
  endtask

  task automatic test_load_commit;
    load(9'h010, 10'd100, 10'd200);
    checks++; if ({shape_ready, busy, pending} !== 3'b001) $display("FAIL load_pending got %b exp 001", {shape_ready, busy, pending}); else passes++;
    commit;
    checks++; if ({shape_ready, busy, pending} !== 3'b100) $display("FAIL commit_idle got %b exp 100", {shape_ready, busy, pending}); else passes++;
  endtask

  task automatic test_pixels;
    logic [9:0] xs [7] = '{10'd108, 10'd100, 10'd116, 10'd101, 10'd114, 10'd115, 10'd99};
    logic [9:0] ys [7] = '{10'd208, 10'd205, 10'd208, 10'd201, 10'd214, 10'd208, 10'd208};
    logic [2:0] ex [7] = '{3'b110, 3'b101, 3'b100, 3'b110, 3'b110, 3'b101, 3'b100};
    logic [2:0] o;
    for (int i = 0; i < 7; i++) begin
      send_pix(xs[i], ys[i], o);
      checks++; if (o !== ex[i]) $display("FAIL pix_%0d (%0d,%0d) got %b exp %b", i, xs[i], ys[i], o, ex[i]); else passes++;
    end
    tick;
    checks++; if (out_valid !== 1'b0) $display("FAIL valid_drop got %b exp 0", out_valid); else passes++;
  endtask

  task automatic test_back_to_back;
    pix_valid = 1'b1; pix_x = 10'd108; pix_y = 10'd208;
    tick;
    pix_x = 10'd100; pix_y = 10'd205;
    tick;
    checks++; if ({out_valid, out_inner, out_edge} !== 3'b110) $display("FAIL b2b_0 got %b exp 110", {out_valid, out_inner, out_edge}); else passes++;
    pix_x = 10'd116; pix_y = 10'd208;
    tick;
    checks++; if ({out_valid, out_inner, out_edge} !== 3'b101) $display("FAIL b2b_1 got %b exp 101", {out_valid, out_inner, out_edge}); else passes++;
    pix_valid = 1'b0;
    tick;
    checks++; if ({out_valid, out_inner, out_edge} !== 3'b100) $display("FAIL b2b_2 got %b exp 100", {out_valid, out_inner, out_edge}); else passes++;
    tick;
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_end got %b exp 0", out_valid); else passes++;
  endtask

  task automatic test_staged_commit;
    logic [2:0] o;
    load(9'h001, 10'd100, 10'd200);
    send_pix(10'd108, 10'd208, o);
    checks++; if (o !== 3'b110) $display("FAIL precommit_centre got %b exp 110", o); else passes++;
    send_pix(10'd90, 10'd190, o);
    checks++; if (o !== 3'b100) $display("FAIL precommit_corner got %b exp 100", o); else passes++;
    frame_start = 1'b1; pix_valid = 1'b1; pix_x = 10'd90; pix_y = 10'd190;
    tick;
    frame_start = 1'b0;
    tick;
    checks++; if ({out_valid, out_inner, out_edge} !== 3'b100) $display("FAIL commit_cycle_old got %b exp 100", {out_valid, out_inner, out_edge}); else passes++;
    pix_valid = 1'b0;
    tick;
    checks++; if ({out_valid, out_inner, out_edge} !== 3'b110) $display("FAIL commit_cycle_new got %b exp 110", {out_valid, out_inner, out_edge}); else passes++;
    send_pix(10'd108, 10'd208, o);
    checks++; if (o !== 3'b100) $display("FAIL postcommit_centre got %b exp 100", o); else passes++;
  endtask

  task automatic test_ignore_when_pending;
    logic [2:0] o;
    load(9'h010, 10'd100, 10'd200);
    shape_valid = 1'b1; shape_mask = 9'h100; shape_ref_x = 10'd0; shape_ref_y = 10'd0;
    checks++; if (shape_ready !== 1'b0) $display("FAIL ready_in_pending got %b exp 0", shape_ready); else passes++;
    tick;
    shape_valid = 1'b0;
    commit;
    send_pix(10'd108, 10'd208, o);
    checks++; if (o !== 3'b110) $display("FAIL ignored_load got %b exp 110", o); else passes++;
  endtask

  task automatic test_load_rot_same;
    shape_valid = 1'b1; shape_mask = 9'h001; shape_ref_x = 10'd100; shape_ref_y = 10'd200; rot_req = 1'b1;
    tick;
    shape_valid = 1'b0; rot_req = 1'b0;
    checks++; if ({shape_ready, busy, pending} !== 3'b001) $display("FAIL load_wins got %b exp 001", {shape_ready, busy, pending}); else passes++;
    repeat (3) tick;
    checks++; if ({shape_ready, busy, pending} !== 3'b001) $display("FAIL load_wins_hold got %b exp 001", {shape_ready, busy, pending}); else passes++;
    commit;
  endtask

`ifdef SHAPE_ROTATE_EN
  task automatic test_rotate;
    logic [2:0] o;
    int cnt = 0;
    rot_req = 1'b1;
    tick;
    rot_req = 1'b0;
    while (busy && cnt < 20) begin
      frame_start = (cnt == 4);
      cnt++;
      tick;
    end
    frame_start = 1'b0;
    checks++; if (cnt !== 9) $display("FAIL busy_cycles got %0d exp 9", cnt); else passes++;
    checks++; if ({shape_ready, busy, pending} !== 3'b001) $display("FAIL rot_pending got %b exp 001", {shape_ready, busy, pending}); else passes++;
    commit;
    send_pix(10'd122, 10'd190, o);
    checks++; if (o !== 3'b110) $display("FAIL rot_new_cell got %b exp 110", o); else passes++;
    send_pix(10'd90, 10'd190, o);
    checks++; if (o !== 3'b100) $display("FAIL rot_old_cell got %b exp 100", o); else passes++;
  endtask

  task automatic test_commit_on_entry;
    logic [2:0] o;
    rot_req = 1'b1;
    tick;
    rot_req = 1'b0;
    repeat (8) tick;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    checks++; if ({shape_ready, busy, pending} !== 3'b001) $display("FAIL entry_no_commit got %b exp 001", {shape_ready, busy, pending}); else passes++;
    send_pix(10'd122, 10'd222, o);
    checks++; if (o !== 3'b100) $display("FAIL entry_old_mask got %b exp 100", o); else passes++;
    commit;
    send_pix(10'd122, 10'd222, o);
    checks++; if (o !== 3'b110) $display("FAIL entry_next_commit got %b exp 110", o); else passes++;
  endtask
`else
  task automatic test_rot_ignored;
    rot_req = 1'b1;
    tick;
    rot_req = 1'b0;
    checks++; if ({shape_ready, busy, pending} !== 3'b100) $display("FAIL rot_ignored got %b exp 100", {shape_ready, busy, pending}); else passes++;
    repeat (10) tick;
    checks++; if ({shape_ready, busy, pending} !== 3'b100) $display("FAIL rot_ignored_hold got %b exp 100", {shape_ready, busy, pending}); else passes++;
  endtask
`endif

  task automatic test_reset_mid;
    logic [2:0] o;
    logic [9:0] hx, hy;
`ifdef SHAPE_ROTATE_EN
    hx = 10'd122; hy = 10'd222;
    rot_req = 1'b1;
    tick;
    rot_req = 1'b0;
    repeat (3) tick;
`else
    hx = 10'd90; hy = 10'd190;
`endif
    pix_valid = 1'b1; pix_x = hx; pix_y = hy;
    tick;
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_inner, out_edge} !== 3'b000) $display("FAIL midreset_out got %b exp 000", {out_valid, out_inner, out_edge}); else passes++;
    checks++; if ({shape_ready, busy, pending} !== 3'b100) $display("FAIL midreset_status got %b exp 100", {shape_ready, busy, pending}); else passes++;
    tick;
    rst_n = 1'b1;
    tick;
    send_pix(hx, hy, o);
    checks++; if (o !== 3'b100) $display("FAIL midreset_mask got %b exp 100", o); else passes++;
    checks++; if ({shape_ready, busy, pending} !== 3'b100) $display("FAIL midreset_after got %b exp 100", {shape_ready, busy, pending}); else passes++;
  endtask

  initial begin
    test_reset;
    test_load_commit;
    test_pixels;
    test_back_to_back;
    test_staged_commit;
    test_ignore_when_pending;
    test_load_rot_same;
`ifdef SHAPE_ROTATE_EN
    test_rotate;
    test_commit_on_entry;
`else
    test_rot_ignored;
`endif
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
